spread_clk_gen: RTL and testbench

SPREAD_CLK_GEN -- requirements
Module: spread_clk_gen

---
 rtl/spread_clk_gen_if.sv | 33 +++
 rtl/spread_clk_gen.sv | 169 ++++++++++++++++
 tb/tb_spread_clk_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/spread_clk_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : spread_clk_gen_if
// Purpose  : Configuration handshake bundle for spread_clk_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface spread_clk_gen_if #(
    parameter int CNT_W = 16,
    parameter int SF_W  = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_half;
    logic [SF_W-1:0]  cfg_sf;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_half,
        output cfg_sf,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_half,
        input  cfg_sf,
        output cfg_ready,
        output cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/spread_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spread_clk_gen
// Purpose  : Chip/bit clock generator with run-time half-period and
//            spreading-factor reconfiguration applied on bit boundaries.
//            Optional macro SYNC_IN_EN adds a sync_in phase-reset input.
// Revision : 1.0 - initial release
// ============================================================================
module spread_clk_gen #(
    parameter int CNT_W    = 16,
    parameter int SF_W     = 8,
    parameter int DEF_HALF = 50,
    parameter int DEF_SF   = 8
) (
    input  wire              clk_100,
    input  wire              rst,
    input  wire              en,
`ifdef SYNC_IN_EN
    input  wire              sync_in,
`endif
    spread_clk_gen_if.slave  cfg,
    output logic             clk_chip,
    output logic             chip_stb,
    output logic             clk_bit,
    output logic             bit_stb,
    output logic [SF_W-1:0]  chip_idx
);

    localparam logic [CNT_W-1:0] c_def_half = CNT_W'(DEF_HALF);
    localparam logic [SF_W-1:0]  c_def_sf   = SF_W'(DEF_SF);
    localparam logic [CNT_W-1:0] c_one_cnt  = CNT_W'(1);
    localparam logic [SF_W-1:0]  c_one_sf   = SF_W'(1);
    localparam logic [SF_W-1:0]  c_two_sf   = SF_W'(2);

    logic [CNT_W-1:0] r_half_cnt,  w_half_cnt_nxt;
    logic             r_clk_chip,  w_clk_chip_nxt;
    logic             r_chip_stb,  w_chip_stb_nxt;
    logic             r_clk_bit,   w_clk_bit_nxt;
    logic             r_bit_stb,   w_bit_stb_nxt;
    logic [SF_W-1:0]  r_chip_idx,  w_chip_idx_nxt;
    logic [CNT_W-1:0] r_act_half,  w_act_half_nxt;
    logic [SF_W-1:0]  r_act_sf,    w_act_sf_nxt;
    logic [CNT_W-1:0] r_pend_half, w_pend_half_nxt;
    logic [SF_W-1:0]  r_pend_sf,   w_pend_sf_nxt;
    logic             r_pend_valid, w_pend_valid_nxt;
    logic             r_cfg_err,   w_cfg_err_nxt;

    logic             w_sync;
    logic             w_wrap;
    logic             w_apply;
    logic             w_cfg_bad;
    logic [SF_W-1:0]  w_idx_inc;

`ifdef SYNC_IN_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    assign w_wrap    = (r_half_cnt == (r_act_half - c_one_cnt));
    assign w_idx_inc = (r_chip_idx >= (r_act_sf - c_one_sf)) ? '0 : (r_chip_idx + c_one_sf);
    assign w_cfg_bad = (cfg.cfg_half == '0) || (cfg.cfg_sf < c_two_sf);

    always_comb begin
        w_half_cnt_nxt   = r_half_cnt;
        w_clk_chip_nxt   = r_clk_chip;
        w_chip_stb_nxt   = 1'b0;
        w_clk_bit_nxt    = r_clk_bit;
        w_bit_stb_nxt    = 1'b0;
        w_chip_idx_nxt   = r_chip_idx;
        w_act_half_nxt   = r_act_half;
        w_act_sf_nxt     = r_act_sf;
        w_pend_half_nxt  = r_pend_half;
        w_pend_sf_nxt    = r_pend_sf;
        w_pend_valid_nxt = r_pend_valid;
        w_cfg_err_nxt    = 1'b0;
        w_apply          = 1'b0;

        if (en) begin
            if (w_sync) begin
                w_half_cnt_nxt = '0;
                w_clk_chip_nxt = 1'b1;
                w_chip_stb_nxt = 1'b1;
                w_chip_idx_nxt = '0;
                w_clk_bit_nxt  = 1'b1;
                w_bit_stb_nxt  = 1'b1;
                w_apply        = r_pend_valid;
            end else if (w_wrap) begin
                w_half_cnt_nxt = '0;
                w_clk_chip_nxt = ~r_clk_chip;
                if (!r_clk_chip) begin
                    w_chip_stb_nxt = 1'b1;
                    w_chip_idx_nxt = w_idx_inc;
                    if (w_idx_inc == '0) begin
                        w_clk_bit_nxt = 1'b1;
                        w_bit_stb_nxt = 1'b1;
                        w_apply       = r_pend_valid;
                    end else if (w_idx_inc == (r_act_sf >> 1)) begin
                        w_clk_bit_nxt = 1'b0;
                    end
                end
            end else begin
                w_half_cnt_nxt = r_half_cnt + c_one_cnt;
            end
        end else begin
            // While stopped there is no bit boundary to wait for.
            w_apply = r_pend_valid;
        end

        if (w_apply) begin
            w_act_half_nxt   = r_pend_half;
            w_act_sf_nxt     = r_pend_sf;
            w_pend_valid_nxt = 1'b0;
            w_half_cnt_nxt   = '0;
            w_chip_idx_nxt   = '0;
        end

        // Only reachable with nothing pending, so it never collides with w_apply.
        if (cfg.cfg_valid && !r_pend_valid) begin
            if (w_cfg_bad) begin
                w_cfg_err_nxt = 1'b1;
            end else begin
                w_pend_half_nxt  = cfg.cfg_half;
                w_pend_sf_nxt    = cfg.cfg_sf;
                w_pend_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_half_cnt   <= '0;
            r_clk_chip   <= 1'b0;
            r_chip_stb   <= 1'b0;
            r_clk_bit    <= 1'b0;
            r_bit_stb    <= 1'b0;
            r_chip_idx   <= c_def_sf - c_one_sf;
            r_act_half   <= c_def_half;
            r_act_sf     <= c_def_sf;
            r_pend_half  <= '0;
            r_pend_sf    <= '0;
            r_pend_valid <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_half_cnt   <= w_half_cnt_nxt;
            r_clk_chip   <= w_clk_chip_nxt;
            r_chip_stb   <= w_chip_stb_nxt;
            r_clk_bit    <= w_clk_bit_nxt;
            r_bit_stb    <= w_bit_stb_nxt;
            r_chip_idx   <= w_chip_idx_nxt;
            r_act_half   <= w_act_half_nxt;
            r_act_sf     <= w_act_sf_nxt;
            r_pend_half  <= w_pend_half_nxt;
            r_pend_sf    <= w_pend_sf_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
        end
    end

    assign clk_chip      = r_clk_chip;
    assign chip_stb      = r_chip_stb;
    assign clk_bit       = r_clk_bit;
    assign bit_stb       = r_bit_stb;
    assign chip_idx      = r_chip_idx;
    assign cfg.cfg_ready = ~r_pend_valid;
    assign cfg.cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_spread_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_spread_clk_gen
// Purpose  : Scoreboard bench for spread_clk_gen; expected chip strobes are
//            queued with their cycle, index and bit-clock state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spread_clk_gen;

    typedef struct {
        int   cyc;
        int   idx;
        logic bstb;
        logic cbit;
    } ev_t;

    logic       clk_100 = 1'b0;
    logic       rst     = 1'b1;
    logic       en      = 1'b0;
`ifdef SYNC_IN_EN
    logic       sync_in = 1'b0;
`endif
    logic       clk_chip, chip_stb, clk_bit, bit_stb;
    logic [7:0] chip_idx;

    int  cyc      = 0;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_fail   = 0;
    ev_t sb[$];

    spread_clk_gen_if #(.CNT_W(16), .SF_W(8)) cfg_if ();

    spread_clk_gen #(.CNT_W(16), .SF_W(8), .DEF_HALF(50), .DEF_SF(8)) dut (
        .clk_100  (clk_100),
        .rst      (rst),
        .en       (en),
`ifdef SYNC_IN_EN
        .sync_in  (sync_in),
`endif
        .cfg      (cfg_if.slave),
        .clk_chip (clk_chip),
        .chip_stb (chip_stb),
        .clk_bit  (clk_bit),
        .bit_stb  (bit_stb),
        .chip_idx (chip_idx)
    );

    always #5 clk_100 = ~clk_100;
    always @(posedge clk_100) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int c, input int idx, input logic b, input logic cb);
        ev_t e;
        e.cyc  = c;
        e.idx  = idx;
        e.bstb = b;
        e.cbit = cb;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_100);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk_100);
        chk("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk_100) begin
        if (bit_stb && !chip_stb) chk("bit_stb_alone", chip_stb, bit_stb);
        if (chip_stb) begin
            if (sb.size() == 0) begin
                chk("unexpected_chip_stb", chip_stb, 1'b0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("stb_cycle", cyc, e.cyc);
                chk("stb_idx", chip_idx, e.idx);
                chk("stb_bit", bit_stb, e.bstb);
                chk("stb_clk_bit", clk_bit, e.cbit);
                chk("stb_clk_chip", clk_chip, 1'b1);
            end
        end
    end

    initial begin
        int r, a, b, c, d, r2;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_half  = '0;
        cfg_if.cfg_sf    = '0;

        // Reset state
        repeat (3) @(negedge clk_100);
        chk("rst_clk_chip", clk_chip, 1'b0);
        chk("rst_clk_bit", clk_bit, 1'b0);
        chk("rst_chip_stb", chip_stb, 1'b0);
        chk("rst_bit_stb", bit_stb, 1'b0);
        chk("rst_cfg_err", cfg_if.cfg_err, 1'b0);
        chk("rst_cfg_ready", cfg_if.cfg_ready, 1'b1);
        chk("rst_chip_idx", chip_idx, 7);

        // Defaults: half 50, sf 8
        rst = 1'b0;
        en  = 1'b1;
        r   = cyc;
        for (int k = 0; k < 16; k++) push_ev(r + 50 + 100 * k, k % 8, (k % 8) == 0, (k % 8) < 4);
        wait_cyc(r + 99);
        chk("chip_high_before_fall", clk_chip, 1'b1);
        wait_cyc(r + 100);
        chk("chip_fall_at_half", clk_chip, 1'b0);
        drain();

        // Reconfigure mid-bit to half 3, sf 5
        a = r + 1650;
        wait_cyc(r + 1560);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_half  = 16'd3;
        cfg_if.cfg_sf    = 8'd5;
        push_ev(a, 0, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++) push_ev(a + 6 * k, k % 5, (k % 5) == 0, (k % 5) < 2);
        wait_cyc(r + 1561);
        chk("ready_low_after_capture", cfg_if.cfg_ready, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        wait_cyc(a - 1);
        chk("ready_low_before_apply", cfg_if.cfg_ready, 1'b0);
        wait_cyc(a);
        chk("ready_high_after_apply", cfg_if.cfg_ready, 1'b1);
        drain();

        // Rejected configurations leave the 6/30 timing intact
        b = a + 90;
        for (int k = 1; k <= 10; k++) push_ev(b + 6 * k, k % 5, (k % 5) == 0, (k % 5) < 2);
        wait_cyc(b + 1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_half  = 16'd4;
        cfg_if.cfg_sf    = 8'd1;
        wait_cyc(b + 2);
        chk("err_sf1_pulse", cfg_if.cfg_err, 1'b1);
        chk("err_sf1_ready", cfg_if.cfg_ready, 1'b1);
        cfg_if.cfg_valid = 1'b0;
        wait_cyc(b + 3);
        chk("err_sf1_one_cycle", cfg_if.cfg_err, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_half  = 16'd0;
        cfg_if.cfg_sf    = 8'd4;
        wait_cyc(b + 4);
        chk("err_half0_pulse", cfg_if.cfg_err, 1'b1);
        chk("err_half0_ready", cfg_if.cfg_ready, 1'b1);
        cfg_if.cfg_valid = 1'b0;
        wait_cyc(b + 5);
        chk("err_half0_one_cycle", cfg_if.cfg_err, 1'b0);
        drain();

        // Freeze for 37 cycles, two cycles into a chip-high half
        c = b + 60;
        wait_cyc(c + 2);
        en = 1'b0;
        for (int j = 0; j < 6; j++) push_ev(c + 43 + 6 * j, (1 + j) % 5, ((1 + j) % 5) == 0, ((1 + j) % 5) < 2);
        wait_cyc(c + 20);
        chk("frz_clk_chip", clk_chip, 1'b1);
        chk("frz_clk_bit", clk_bit, 1'b1);
        chk("frz_chip_idx", chip_idx, 0);
        chk("frz_chip_stb", chip_stb, 1'b0);
        wait_cyc(c + 39);
        en = 1'b1;
        chk("frz_end_clk_chip", clk_chip, 1'b1);
        wait_cyc(c + 40);
        chk("resume_fall", clk_chip, 1'b0);
        drain();

        // Reset with a pending configuration discards it
        d = c + 73;
        wait_cyc(d + 1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_half  = 16'd10;
        cfg_if.cfg_sf    = 8'd3;
        wait_cyc(d + 2);
        chk("pend_ready_low", cfg_if.cfg_ready, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        wait_cyc(d + 4);
        rst = 1'b1;
        wait_cyc(d + 5);
        chk("midrst_clk_chip", clk_chip, 1'b0);
        chk("midrst_clk_bit", clk_bit, 1'b0);
        chk("midrst_chip_idx", chip_idx, 7);
        chk("midrst_ready", cfg_if.cfg_ready, 1'b1);
        chk("midrst_chip_stb", chip_stb, 1'b0);
        rst = 1'b0;
        r2  = cyc;
        for (int k = 0; k < 6; k++) push_ev(r2 + 50 + 100 * k, k % 8, (k % 8) == 0, (k % 8) < 4);
        drain();

`ifdef SYNC_IN_EN
        wait_cyc(r2 + 560);
        sync_in = 1'b1;
        push_ev(r2 + 561, 0, 1'b1, 1'b1);
        push_ev(r2 + 661, 1, 1'b0, 1'b1);
        push_ev(r2 + 761, 2, 1'b0, 1'b1);
        wait_cyc(r2 + 561);
        sync_in = 1'b0;
        chk("sync_idx", chip_idx, 0);
        chk("sync_clk_chip", clk_chip, 1'b1);
`else
        for (int k = 6; k < 9; k++) push_ev(r2 + 50 + 100 * k, k % 8, (k % 8) == 0, (k % 8) < 4);
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
